sub_layer_seq: RTL and testbench

SUB_LAYER_SEQ -- requirements
Module: sub_layer_seq

---
 rtl/sub_layer_pkg.sv | 19 +
 rtl/sub_layer_seq_sbox.sv | 29 ++
 rtl/sub_layer_seq.sv | 88 ++++++++
 tb/tb_sub_layer_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sub_layer_pkg.sv
// Shared constants for the sequential substitution layer: FSM encodings, default width, lane count.
// Lane count follows SUB_LAYER_SEQ_DUAL_EN (two sbox lanes when defined, one otherwise).
package sub_layer_pkg;

    localparam int DEFAULT_N = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

`ifdef SUB_LAYER_SEQ_DUAL_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

endpackage

// File: rtl/sub_layer_seq_sbox.sv
// 4-bit PRESENT substitution box (C56B90AD3EF84712), purely combinational.
module sbox (
    input  logic [3:0] a,
    output logic [3:0] y
);

    always_comb begin
        y = 4'h0;
        case (a)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
    end

endmodule

// File: rtl/sub_layer_seq.sv
// Time-shared nibble substitution layer with a four-phase req/ack handshake.
// Define SUB_LAYER_SEQ_DUAL_EN to process two nibbles per cycle instead of one.
module sub_layer_seq
    import sub_layer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    output logic           ack,
    input  logic [4*N-1:0] x,
    output logic [4*N-1:0] r
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    state_t           state_q, state_d;
    logic [4*N-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] lane_idx [LANES];
    logic [3:0]       nib_in   [LANES];
    logic [3:0]       nib_out  [LANES];

    // Lane gi works on nibble idx+gi; idx is always lane-aligned so no lane runs past N-1.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_idx[gi] = idx_q + IDX_W'(gi);
        assign nib_in[gi]   = buf_q[{lane_idx[gi], 2'b00} +: 4];

        sbox u_sbox (
            .a (nib_in[gi]),
            .y (nib_out[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: if (!req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    buf_d = x;
                    idx_d = '0;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    buf_d[{lane_idx[l], 2'b00} +: 4] = nib_out[l];
                end
                // Idx parks on the last lane group rather than wrapping.
                if (idx_q != LAST_IDX) idx_d = idx_q + IDX_STEP;
            end
            default: ;
        endcase
    end

    // The buffer holds a partial result only while in RUN, so r is blanked there.
    always_comb begin
        ack = (state_q == ST_DONE);
        r   = (state_q == ST_RUN) ? '0 : buf_q;
    end

endmodule

// File: tb/tb_sub_layer_seq.sv
// Scoreboard bench for sub_layer_seq (N=16): expected results queued at capture, checked at ack.
module tb_sub_layer_seq;

    localparam int N = 16;
`ifdef SUB_LAYER_SEQ_DUAL_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          ack;
    logic [63:0]   x = '0;
    logic [63:0]   r;

    int total = 0;
    int bad   = 0;
    logic [63:0] scb [$];

    sub_layer_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
        .x     (x),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] v);
        case (v)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < N; i++) o[4*i +: 4] = sb(v[4*i +: 4]);
        return o;
    endfunction

    // mode 0: req held through DONE; 1: one-cycle req pulse; 2: held, x changed during RUN
    task automatic run_op(input logic [63:0] xv, input logic [63:0] exp_r, input int mode);
        int edges;
        bit got;
        logic [63:0] e;
        @(negedge clk);
        x = xv;
        req = 1'b1;
        scb.push_back(exp_r);
        @(posedge clk);
        @(negedge clk);
        if (mode == 1) req = 1'b0;
        if (mode == 2) x = ~xv;
        edges = 0;
        got = 0;
        while (!got && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ack) got = 1;
        end
        chk("ack_latency", 64'(edges), 64'(LAT));
        if (!got) begin
            chk("ack_timeout", 64'(ack), 64'd1);
            void'(scb.pop_front());
            return;
        end
        e = scb.pop_front();
        chk("r_result", r, e);
        if (mode == 1) begin
            @(negedge clk);
            chk("ack_one_cycle", 64'(ack), 64'd0);
            repeat (3) @(negedge clk);
            chk("r_held_idle", r, e);
            chk("no_restart_ack", 64'(ack), 64'd0);
        end else begin
            repeat (3) begin
                @(negedge clk);
                chk("ack_hold", 64'(ack), 64'd1);
                chk("r_hold", r, e);
            end
            req = 1'b0;
            @(negedge clk);
            chk("ack_drop", 64'(ack), 64'd0);
            chk("r_after_drop", r, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rv;
        #3;
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_r", r, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ack", 64'(ack), 64'd0);

        run_op(64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712, 0);
        run_op(64'hFEDC_BA98_7654_3210, model(64'hFEDC_BA98_7654_3210), 1);
        run_op(64'h1357_9BDF_0246_8ACE, model(64'h1357_9BDF_0246_8ACE), 2);

        // abort mid-RUN with reset, then a fresh operation
        @(negedge clk);
        x = 64'hA5A5_A5A5_A5A5_A5A5;
        req = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ack", 64'(ack), 64'd0);
        chk("abort_r", r, 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_ack", 64'(ack), 64'd0);
        chk("post_abort_r", r, 64'd0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h2222_2222_2222_2222, 0);

        for (int k = 0; k < 3; k++) begin
            rv = {$urandom, $urandom};
            run_op(rv, model(rv), k % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
